pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It combines the load-use/branch-operand stall from hazard detection with instruction- and data-cache miss stalls and ID-stage branch/jump redirects. From these it drives every pipeline-register write enable, flush (bubble) control and the next-PC select. It also latches a redirect taken during an outstanding I-cache miss and applies it when the fetch completes, and keeps two saturating performance counters.

## Interface
- CNT_W, 32, width of the performance counters.
- ADDR_W, 32, PC width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hazard_stall  in  1  stall request from hazard detection (load-use or branch operand not ready).
- branch_taken  in  1  ID-stage branch/J/Jr resolved taken.
- branch_target  in  ADDR_W  ID-stage target, valid with branch_taken.
- icache_stall  in  1  I-cache miss outstanding; the current fetch is not ready.
- dcache_stall  in  1  D-cache miss outstanding; the MEM stage cannot complete.
- pc_we  out  1  PC write enable.
- next_pc_sel  out  2  0 = PC+4, 1 = live branch_target, 2 = redirect_pc.
- redirect_pc  out  ADDR_W  latched redirect target.
- ifid_we, ifid_flush  out  1 each  IF/ID write enable; flush loads a bubble (flush takes effect only when ifid_we=1).
- idex_we, idex_flush  out  1 each  ID/EX write enable; flush loads a bubble.
- exmem_we, memwb_we  out  1 each  EX/MEM and MEM/WB write enables.
- stall_cnt  out  CNT_W  count of cycles with any stall.
- redir_cnt  out  CNT_W  count of redirects (bubbles inserted into IF/ID).

## Operation
- State machine with two states:
  - RUN.
  - IMISS_REDIR: a redirect is pending behind an I-cache miss.
- Outputs are combinational from state and inputs. Evaluate per cycle in this priority order:
  1. **dcache_stall=1 (any state):** all *_we=0, all flushes=0, pc_we=0. State, redirect_pc and pending status are held. branch_taken is ignored; the branch stays in ID and is re-presented.
  2. **RUN, hazard_stall=1:**
     - pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, exmem_we=memwb_we=1.
     - branch_taken is ignored.
  3. **RUN, icache_stall=1, branch_taken=0:**
     - pc_we=0; ifid_we=1 with ifid_flush=1, so ID receives a bubble and the instruction in ID advances.
     - idex/exmem/memwb_we=1, no flushes.
  4. **RUN, icache_stall=1, branch_taken=1:**
     - Same outputs as rule 3.
     - Latch redirect_pc<=branch_target; move to IMISS_REDIR.
  5. **RUN, branch_taken=1, no stalls:**
     - pc_we=1, next_pc_sel=1.
     - ifid_we=1, ifid_flush=1 (no delay slot); all later stages enabled.
     - redir_cnt increments.
  6. **RUN, no events:** all we=1, next_pc_sel=0, no flushes.
  7. **IMISS_REDIR, icache_stall=1:** same outputs as rule 3; stay in IMISS_REDIR.
  8. **IMISS_REDIR, icache_stall=0:**
     - pc_we=1, next_pc_sel=2.
     - ifid_we=1, ifid_flush=1, discarding the wrong-path fetch.
     - redir_cnt increments; return to RUN.
     - hazard_stall in this cycle still forces idex_flush=1.
- In IMISS_REDIR, branch_taken=1 is illegal (ID holds bubbles). It is ignored and flagged by a simulation-only assertion.
- Counters:
  - stall_cnt increments when any of hazard_stall, icache_stall or dcache_stall is high.
  - Both counters saturate at all-ones and do not wrap.

## Timing
- Control outputs have zero latency: they are valid in the same cycle as the inputs.
- The redirect latch, state and counters update on the rising edge of clk.
- A pending redirect applies on the first cycle with icache_stall=0 and dcache_stall=0. The minimum is one cycle after the latch.
- Reset (asynchronous, any time, including mid-miss):
  - state=RUN, redirect_pc=0, stall_cnt=0, redir_cnt=0.
  - While rst_n=0, outputs are as in RUN with no events: we=1, sel=0, flushes=0.
  - A pending redirect is discarded.
- dcache_stall and icache_stall together: dcache_stall wins; the state is frozen.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, IMISS_REDIR);
  - the next_pc_sel encodings PC_SEQ=0, PC_BR=1, PC_REDIR=2.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count), instantiated twice.

## Test plan
- **Load-use:** hazard_stall=1 for one cycle in RUN → pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1; stall_cnt 0→1.
- **Taken branch:** branch_taken=1, branch_target=0x0000_0040, no stalls → pc_we=1, next_pc_sel=1, ifid_flush=1; redir_cnt=1.
- **Redirect during I-miss:**
  - Stimulus: icache_stall=1 for 4 cycles; branch_taken=1 with target 0x0000_0100 in cycle 1.
  - Cycles 1–4: pc_we=0, IF/ID bubble each cycle; redirect_pc=0x100 from cycle 2.
  - Cycle 5: pc_we=1, next_pc_sel=2, ifid_flush=1, state returns to RUN.
- **D-cache freeze:** dcache_stall=1 for 3 cycles while in IMISS_REDIR with icache_stall=0 → all we=0 for 3 cycles, redirect_pc held; redirect applies on cycle 4.
- **Reset mid-operation:** rst_n pulsed low in IMISS_REDIR → state=RUN, redirect_pc=0, counters=0 immediately; the next cycle with icache_stall=0 uses next_pc_sel=0.
- **Counter saturation:** with CNT_W=4, hold hazard_stall for 20 cycles → stall_cnt=15 and holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   // RUN: normal operation; IMISS_REDIR: a redirect waits behind an I-cache miss
   typedef enum logic {
      RUN         = 1'b0,
      IMISS_REDIR = 1'b1
   } state_e;

   // next_pc_sel encodings
   localparam logic [1:0] PC_SEQ   = 2'd0;
   localparam logic [1:0] PC_BR    = 2'd1;
   localparam logic [1:0] PC_REDIR = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next value: step only when requested and not already saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Combines hazard,
// I-cache and D-cache stalls with ID-stage redirects into pipeline-register
// write enables, bubble controls and the next-PC select. A redirect that
// resolves while the fetch is missing is parked and replayed on fetch return.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hazard_stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              icache_stall,
   input  logic              dcache_stall,
   output logic              pc_we,
   output logic [1:0]        next_pc_sel,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              ifid_we,
   output logic              ifid_flush,
   output logic              idex_we,
   output logic              idex_flush,
   output logic              exmem_we,
   output logic              memwb_we,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  redir_cnt
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] redirect_q, redirect_d;
   logic              redir_inc;
   logic              stall_inc;

   // Per-cycle control decode in priority order; D-cache miss freezes everything
   always_comb begin
      pc_we       = 1'b1;
      next_pc_sel = PC_SEQ;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_flush  = 1'b0;
      exmem_we    = 1'b1;
      memwb_we    = 1'b1;
      state_d     = state_q;
      redirect_d  = redirect_q;
      redir_inc   = 1'b0;

      if (!rst_n) begin
         // while held in reset the pipeline free-runs sequentially
      end else if (dcache_stall) begin
         pc_we    = 1'b0;
         ifid_we  = 1'b0;
         idex_we  = 1'b0;
         exmem_we = 1'b0;
         memwb_we = 1'b0;
      end else if (state_q == RUN) begin
         if (hazard_stall) begin
            // hold IF and ID, push a bubble into EX
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
         end else if (icache_stall) begin
            // fetch not ready: let ID drain, feed it a bubble
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            if (branch_taken) begin
               redirect_d = branch_target;
               state_d    = IMISS_REDIR;
            end
         end else if (branch_taken) begin
            next_pc_sel = PC_BR;
            ifid_flush  = 1'b1;
            redir_inc   = 1'b1;
         end
      end else begin
         if (icache_stall) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
         end else begin
            // fetch returned: discard the wrong-path word and jump
            next_pc_sel = PC_REDIR;
            ifid_flush  = 1'b1;
            idex_flush  = hazard_stall;
            redir_inc   = 1'b1;
            state_d     = RUN;
         end
      end
   end

   // State and parked redirect target
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         redirect_q <= '0;
      end else begin
         state_q    <= state_d;
         redirect_q <= redirect_d;
      end
   end

   assign redirect_pc = redirect_q;
   assign stall_inc   = hazard_stall | icache_stall | dcache_stall;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_redir_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (redir_inc),
      .count (redir_cnt)
   );

`ifndef SYNTHESIS
   // ID only holds bubbles while a redirect is parked, so no branch can resolve
   a_no_branch_in_redir: assert property (@(posedge clk) disable iff (!rst_n)
      !((state_q == IMISS_REDIR) && branch_taken));
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios followed by random
// traffic, each cycle checked against a rule-level reference model.
module tb_pipeline_ctrl;

   localparam int CW = 4;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hazard_stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic          icache_stall = 1'b0;
   logic          dcache_stall = 1'b0;
   logic          pc_we;
   logic [1:0]    next_pc_sel;
   logic [AW-1:0] redirect_pc;
   logic          ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we;
   logic [CW-1:0] stall_cnt, redir_cnt;

   pipeline_ctrl #(.CNT_W(CW), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .hazard_stall  (hazard_stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .icache_stall  (icache_stall),
      .dcache_stall  (dcache_stall),
      .pc_we         (pc_we),
      .next_pc_sel   (next_pc_sel),
      .redirect_pc   (redirect_pc),
      .ifid_we       (ifid_we),
      .ifid_flush    (ifid_flush),
      .idex_we       (idex_we),
      .idex_flush    (idex_flush),
      .exmem_we      (exmem_we),
      .memwb_we      (memwb_we),
      .stall_cnt     (stall_cnt),
      .redir_cnt     (redir_cnt)
   );

   always #5 clk = ~clk;

   // Expected snapshot: {pc_we, sel, ifid_we, ifid_flush, idex_we, idex_flush,
   //                     exmem_we, memwb_we, redirect_pc, stall_cnt, redir_cnt}
   typedef logic [9+AW+2*CW-1:0] snap_t;
   typedef struct {
      snap_t      v;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   // Reference model: architectural view (a pending-redirect flag and target,
   // two plain integer counters clamped at the maximum)
   bit            m_pend = 1'b0;
   logic [AW-1:0] m_tgt = '0;
   int            m_sc = 0, m_rc = 0;
   bit            n_pend = 1'b0;
   logic [AW-1:0] n_tgt = '0;
   int            n_sc = 0, n_rc = 0;
   localparam int CMAX = (1 << CW) - 1;

   task automatic step(input bit rn, input bit hz, input bit br,
                       input logic [AW-1:0] tg, input bit ic, input bit dc,
                       input string tag);
      bit pw, iw, ifl, xw, xfl, ew, mw;
      logic [1:0] sel;
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      // the edge that just happened committed last cycle's outcome
      m_pend = n_pend; m_tgt = n_tgt; m_sc = n_sc; m_rc = n_rc;
      if (!rn) begin
         m_pend = 1'b0; m_tgt = '0; m_sc = 0; m_rc = 0;
      end
      rst_n = rn; hazard_stall = hz; branch_taken = br; branch_target = tg;
      icache_stall = ic; dcache_stall = dc;

      pw = 1; sel = 2'd0; iw = 1; ifl = 0; xw = 1; xfl = 0; ew = 1; mw = 1;
      n_pend = m_pend; n_tgt = m_tgt; n_sc = m_sc; n_rc = m_rc;
      if (rn) begin
         if (dc) begin
            pw = 0; iw = 0; xw = 0; ew = 0; mw = 0;
         end else if (!m_pend) begin
            if (hz) begin
               pw = 0; iw = 0; xfl = 1;
            end else if (ic) begin
               pw = 0; ifl = 1;
               if (br) begin n_pend = 1; n_tgt = tg; end
            end else if (br) begin
               sel = 2'd1; ifl = 1; n_rc = m_rc + 1;
            end
         end else begin
            if (ic) begin
               pw = 0; ifl = 1;
            end else begin
               sel = 2'd2; ifl = 1; xfl = hz; n_rc = m_rc + 1; n_pend = 0;
            end
         end
         if (hz || ic || dc) n_sc = m_sc + 1;
         if (n_sc > CMAX) n_sc = CMAX;
         if (n_rc > CMAX) n_rc = CMAX;
      end
      e.v = {pw, sel, iw, ifl, xw, xfl, ew, mw, m_tgt, CW'(m_sc), CW'(m_rc)};
      e.tag = tag;
      q.push_back(e);
   endtask

   // Monitor: compares the DUT against the oldest expectation mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         snap_t act;
         e = q.pop_front();
         act = {pc_we, next_pc_sel, ifid_we, ifid_flush, idex_we, idex_flush,
                exmem_we, memwb_we, redirect_pc, stall_cnt, redir_cnt};
         tests++;
         if (act !== e.v) begin
            fails++;
            $display("FAIL %s cyc %0d: got %h want %h", e.tag, cyc, act, e.v);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rn, hz, br, ic, dc;
      logic [AW-1:0] tg;
      // reset state
      step(0, 0, 0, '0, 0, 0, "reset");
      step(0, 1, 0, '0, 1, 1, "reset_ignores_inputs");
      // load-use
      step(1, 0, 0, '0, 0, 0, "idle");
      step(1, 1, 0, '0, 0, 0, "load_use");
      step(1, 0, 0, '0, 0, 0, "after_load_use");
      // taken branch
      step(1, 0, 1, 32'h0000_0040, 0, 0, "taken_branch");
      step(1, 0, 0, '0, 0, 0, "after_branch");
      // redirect during I-miss
      step(1, 0, 1, 32'h0000_0100, 1, 0, "imiss_c1");
      step(1, 0, 0, '0, 1, 0, "imiss_c2");
      step(1, 0, 0, '0, 1, 0, "imiss_c3");
      step(1, 0, 0, '0, 1, 0, "imiss_c4");
      step(1, 0, 0, '0, 0, 0, "imiss_apply");
      step(1, 0, 0, '0, 0, 0, "imiss_back_run");
      // D-cache freeze while a redirect is parked
      step(1, 0, 1, 32'h0000_0200, 1, 0, "dfrz_latch");
      for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, 1, "dfrz_hold");
      step(1, 0, 0, '0, 0, 0, "dfrz_apply");
      // both cache stalls: D-cache wins
      step(1, 0, 1, 32'h0000_0300, 1, 0, "both_latch");
      step(1, 1, 0, '0, 1, 1, "both_stalls");
      step(1, 1, 0, '0, 0, 0, "redir_with_hazard");
      // reset mid-operation
      step(1, 0, 1, 32'h0000_0400, 1, 0, "rst_latch");
      step(0, 0, 0, '0, 1, 0, "rst_mid_miss");
      step(1, 0, 0, '0, 0, 0, "rst_after_seq");
      // counter saturation
      step(0, 0, 0, '0, 0, 0, "sat_reset");
      for (int i = 0; i < 20; i++) step(1, 1, 0, '0, 0, 0, "sat_hazard");
      step(1, 0, 0, '0, 0, 0, "sat_hold");
      step(1, 0, 0, '0, 0, 0, "sat_hold2");
      // random traffic
      step(0, 0, 0, '0, 0, 0, "rand_reset");
      for (int i = 0; i < 3000; i++) begin
         rn = ($urandom_range(0, 99) != 0);
         hz = ($urandom_range(0, 3) == 0);
         ic = ($urandom_range(0, 2) == 0);
         dc = ($urandom_range(0, 5) == 0);
         // a branch cannot resolve while a redirect is parked
         br = (!n_pend || !rn) ? ($urandom_range(0, 2) == 0) : 1'b0;
         tg = $urandom;
         step(rn, hz, br, tg, ic, dc, "random");
      end
      @(posedge clk);
      @(posedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
